// File: rtl/button_pkg.sv
// Shared types and width helpers for the push-button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_t;

  // Bits needed to hold every value 0..max_val; never less than one bit.
  function automatic int ctr_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: synchronizer, tick-sampled debounce, press/release pulses,
// long-press detection and auto-repeat.
module button_channel
  import button_pkg::*;
#(
  parameter int ACTIVE_LOW   = 1,
  parameter int STABLE_TICKS = 10,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       din,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic       long_press,
  output logic       rpt,
  output logic [1:0] state_dbg
);

  localparam int CW = ctr_width(STABLE_TICKS);
  localparam int HW = ctr_width(max2(LONG_TICKS, REPEAT_TICKS));
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] RPT_LAST  = HW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
  localparam logic [HW-1:0] HOLD_MAX  = '1;
  localparam logic          INACTIVE  = (ACTIVE_LOW != 0);

  logic [1:0]    sync_q;
  logic          s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_d;
  logic          press_evt, release_evt;
  btn_state_t    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          long_d, rpt_d;

  // Flops reset to the idle pin level so reset release never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {2{INACTIVE}};
    else        sync_q <= {sync_q[0], din};
  end

  assign s = sync_q[1] ^ INACTIVE;

  always_comb begin
    cnt_d       = cnt_q;
    level_d     = level;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    if (tick) begin
      if (s == level) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d       = '0;
        level_d     = s;
        press_evt   = s;
        release_evt = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // A release overrides any long/repeat pulse that would land on the same tick.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    if (release_evt) begin
      state_d = IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press_evt) begin
            state_d = PRESSED;
            hold_d  = '0;
          end
        end
        PRESSED: begin
          if (tick) begin
            if (hold_q == LONG_LAST) begin
              long_d  = 1'b1;
              state_d = HELD;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        HELD: begin
          if (tick) begin
            if (REPEAT_TICKS == 0) begin
              if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
            end else if (hold_q == RPT_LAST) begin
              rpt_d  = 1'b1;
              hold_d = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          hold_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      level      <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      long_press <= 1'b0;
      rpt        <= 1'b0;
      state_q    <= IDLE;
      hold_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      level      <= level_d;
      rise       <= press_evt;
      fall       <= release_evt;
      long_press <= long_d;
      rpt        <= rpt_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: shared sampling tick plus one
// independent conditioner per channel.
module button_conditioner
  import button_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int EXT_TICK     = 0,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_en,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   level,
  output logic [WIDTH-1:0]   rise,
  output logic [WIDTH-1:0]   fall,
  output logic [WIDTH-1:0]   long_press,
  output logic [WIDTH-1:0]   rpt,
  output logic               tick,
  output logic [2*WIDTH-1:0] state_dbg
);

  localparam int PW = ctr_width(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q;
  logic          pre_tick;

  assign pre_tick = (pre_q == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pre_q <= '0;
    else if (pre_tick) pre_q <= '0;
    else               pre_q <= pre_q + 1'b1;
  end

  assign tick = (EXT_TICK != 0) ? tick_en : pre_tick;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    button_channel #(
      .ACTIVE_LOW  (ACTIVE_LOW),
      .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .din       (din[i]),
      .level     (level[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .long_press(long_press[i]),
      .rpt       (rpt[i]),
      .state_dbg (state_dbg[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: event scoreboard on the prescaled instance,
// step table on the externally ticked instance.
module tb_button_conditioner;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = 2'b11;
  logic [W-1:0] din_x = 2'b11;
  logic         tick_en = 1'b0;

  logic [W-1:0]   level, rise, fall, long_press, rpt;
  logic           tick;
  logic [2*W-1:0] state_dbg;
  logic [W-1:0]   level_x, rise_x, fall_x, long_x, rpt_x;
  logic           tick_x;
  logic [2*W-1:0] state_dbg_x;

  button_conditioner #(
    .WIDTH(W), .ACTIVE_LOW(1), .EXT_TICK(0), .TICK_DIV(4),
    .STABLE_TICKS(3), .LONG_TICKS(10), .REPEAT_TICKS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_en(1'b0), .din(din),
    .level(level), .rise(rise), .fall(fall), .long_press(long_press),
    .rpt(rpt), .tick(tick), .state_dbg(state_dbg)
  );

  button_conditioner #(
    .WIDTH(W), .ACTIVE_LOW(1), .EXT_TICK(1), .TICK_DIV(4),
    .STABLE_TICKS(3), .LONG_TICKS(10), .REPEAT_TICKS(0)
  ) dut_x (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .din(din_x),
    .level(level_x), .rise(rise_x), .fall(fall_x), .long_press(long_x),
    .rpt(rpt_x), .tick(tick_x), .state_dbg(state_dbg_x)
  );

  // clock / reset-relative cycle count
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // scoreboard word: {cycle, kind (0 rise, 1 fall, 2 long, 3 rpt), channel mask}
  logic [31:0] exp_q[$];
  logic        mon_en = 1'b0;

  function automatic logic [31:0] ev(input int c, input int kind, input logic [1:0] mask);
    return {c[27:0], kind[1:0], mask};
  endfunction

  // First tick-evaluation edge that sees a pin change driven at negedge c.
  function automatic int first_eval(input int c);
    return ((c + 6) / 4) * 4;
  endfunction

  always @(negedge clk) begin : monitor
    logic [1:0] v;
    if (mon_en) begin
      while (exp_q.size() > 0 && int'(exp_q[0][31:4]) < cyc)
        check("missed_event", 32'h0, exp_q.pop_front());
      for (int k = 0; k < 4; k++) begin
        v = (k == 0) ? rise : (k == 1) ? fall : (k == 2) ? long_press : rpt;
        if (v != 2'b00) begin
          if (exp_q.size() == 0) check("unexpected_event", ev(cyc, k, v), 32'h0);
          else                   check("event", ev(cyc, k, v), exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_until(input int t);
    int guard = 0;
    while (cyc < t && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < t) check("wait_timeout", cyc, t);
  endtask

  typedef struct {
    logic din0;
    logic lvl;
    logic rise;
    logic fall;
    logic lng;
  } vec_t;

  initial begin
    int   e, base, e2;
    logic idle_bits;
    vec_t tbl [28];

    // external-tick steps: one tick per entry, channel 1 never pressed
    for (int i = 0; i < 28; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[24] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[25] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[26] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[27] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // reset and quiet idle with both pins released
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({level, rise, fall, long_press, rpt, tick}), 32'h0);
    check("reset_state", 32'(state_dbg), 32'h0);
    mon_en = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check("tick_phase", 32'(tick), 32'((cyc % 4) == 3));
      check("idle_level", 32'(level), 32'h0);
    end

    // press, long press, repeats, release colliding with a repeat tick
    din[0] = 1'b0;
    e = first_eval(cyc) + 8;
    exp_q.push_back(ev(e, 0, 2'b01));
    exp_q.push_back(ev(e + 40, 2, 2'b01));
    exp_q.push_back(ev(e + 56, 3, 2'b01));
    exp_q.push_back(ev(e + 72, 3, 2'b01));
    wait_until(e - 1);
    check("level_before_rise", 32'(level), 32'h0);
    wait_until(e);
    check("level_at_rise", 32'(level), 32'h1);
    wait_until(e + 76);
    din[0] = 1'b1;
    exp_q.push_back(ev(e + 88, 1, 2'b01));
    wait_until(e + 87);
    check("level_before_fall", 32'(level), 32'h1);
    wait_until(e + 88);
    check("level_at_fall", 32'(level), 32'h0);
    wait_until(e + 130);

    // bounce 0,1,0 on consecutive ticks, then steady pressed
    while (cyc % 4 != 1) @(negedge clk);
    base = cyc;
    din[0] = 1'b0;
    wait_until(base + 4);
    din[0] = 1'b1;
    wait_until(base + 8);
    din[0] = 1'b0;
    exp_q.push_back(ev(base + 19, 0, 2'b01));
    wait_until(base + 15);
    check("bounce_level_low", 32'(level), 32'h0);
    wait_until(base + 19);
    check("bounce_level_high", 32'(level), 32'h1);
    wait_until(base + 20);
    din[0] = 1'b1;
    exp_q.push_back(ev(base + 31, 1, 2'b01));
    wait_until(base + 60);

    // reset while HELD, pin kept pressed through reset
    din[0] = 1'b0;
    e2 = first_eval(cyc) + 8;
    exp_q.push_back(ev(e2, 0, 2'b01));
    exp_q.push_back(ev(e2 + 40, 2, 2'b01));
    wait_until(e2 + 46);
    check("state_held", 32'(state_dbg), 32'h2);
    #2 rst_n = 1'b0;
    #1 check("async_clear", 32'({level, rise, fall, long_press, rpt}), 32'h0);
    check("async_state", 32'(state_dbg), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(ev(12, 0, 2'b01));
    wait_until(11);
    check("repress_level_low", 32'(level), 32'h0);
    wait_until(12);
    check("repress_level_high", 32'(level), 32'h1);
    wait_until(13);
    din[0] = 1'b1;
    exp_q.push_back(ev(24, 1, 2'b01));
    wait_until(60);
    check("released_level", 32'(level), 32'h0);

    // external tick every 7 clk, repeat disabled
    for (int i = 0; i < 28; i++) begin
      din_x[0] = tbl[i].din0;
      idle_bits = 1'b0;
      repeat (6) begin
        @(negedge clk);
        idle_bits = idle_bits | (|{rise_x, fall_x, long_x, rpt_x});
      end
      check("ext_idle_pulses", 32'(idle_bits), 32'h0);
      tick_en = 1'b1;
      #1 check("ext_tick", 32'(tick_x), 32'h1);
      @(negedge clk);
      tick_en = 1'b0;
      check($sformatf("ext_step%0d", i),
            32'({level_x, rise_x, fall_x, long_x, rpt_x}),
            32'({1'b0, tbl[i].lvl, 1'b0, tbl[i].rise, 1'b0, tbl[i].fall,
                 1'b0, tbl[i].lng, 2'b00}));
    end

    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Multi-channel push-button front end. It is the next generation of the single-purpose debouncer.
- Per channel: 2-flop synchronizer, polarity normalisation, tick-sampled debounce, one-cycle press/release pulses, long-press detection and auto-repeat.
- Sampling tick comes from an internal prescaler or an external strobe.
- Sits between board pins (KEY/SW) and the control FSMs, which consume single-cycle event pulses instead of raw levels.

Parameters:
WIDTH, 4, number of independent channels
ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; applied after synchronizer so internal "pressed" = 1
EXT_TICK, 0, 1 = use tick_en input; 0 = internal prescaler, tick_en ignored
TICK_DIV, 50000, prescaler period in clk cycles (>=1); 1 = tick every cycle
STABLE_TICKS, 10, consecutive differing samples required to change state (>=1)
LONG_TICKS, 1000, ticks of debounced hold before long_press (>=1)
REPEAT_TICKS, 200, ticks between repeat pulses after long_press; 0 disables repeat

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick_en  in  1  external sampling strobe, one clk wide (used only when EXT_TICK=1)
din  in  WIDTH  raw asynchronous pin levels
level  out  WIDTH  debounced pressed level (1 = pressed)
rise  out  WIDTH  one-clk pulse on debounced press
fall  out  WIDTH  one-clk pulse on debounced release
long_press  out  WIDTH  one-clk pulse when hold reaches LONG_TICKS
rpt  out  WIDTH  one-clk auto-repeat pulse
tick  out  1  active sampling strobe (for observation)

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; all counters 0; channel state IDLE.
  - Synchronizer flops reset to the inactive pin level (ACTIVE_LOW ? 1 : 0), so no event fires on reset release.
- Tick, internal (EXT_TICK=0):
  - Counter counts 0..TICK_DIV-1; tick=1 for exactly one clk when the counter equals TICK_DIV-1, then wraps to 0.
  - First tick comes TICK_DIV cycles after reset release.
- Tick, external (EXT_TICK=1): tick = tick_en combinationally.
- Sync: s = din after 2 flops, inverted if ACTIVE_LOW. Latency pin-to-s is 2 clk.
- Debounce, per channel, evaluated only on tick:
  - If s == level: cnt <= 0.
  - Else if cnt == STABLE_TICKS-1: level <= s, cnt <= 0.
  - Else cnt <= cnt+1.
  - level therefore changes on the STABLE_TICKS-th consecutive tick with s != level. Any matching sample restarts the count.
- Events:
  - rise/fall are registered and assert in the same clk that level updates (the edge after the tick), for 1 clk only.
- Per-channel FSM (states in shared enum):
  - IDLE: level=0. On a debounced press -> PRESSED, hold <= 0.
  - PRESSED: each tick hold <= hold+1. When hold reaches LONG_TICKS-1 on a tick, pulse long_press and go to HELD with hold <= 0.
  - HELD: if REPEAT_TICKS=0, stay idle-counting (hold saturates, no pulses). Otherwise count ticks; on hold == REPEAT_TICKS-1 pulse rpt and set hold <= 0.
  - Any debounced release, from any state -> IDLE, fall pulse, hold <= 0. Release wins over a simultaneous long_press/rpt on the same tick, so no long/rpt pulse is issued.
- Widths:
  - cnt is $clog2(STABLE_TICKS+1).
  - hold is $clog2(max(LONG_TICKS,REPEAT_TICKS)+1).
  - Prescaler is $clog2(TICK_DIV+1).
  - Counters never wrap past their terminal value.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- Reset during a press: outputs clear immediately. If the pin is still pressed after release, rise fires after STABLE_TICKS ticks, as for a fresh press.
- Glitches shorter than 2 clk may be missed by the synchronizer. This is acceptable.

Decomposition:
- Package button_pkg: channel state enum {IDLE, PRESSED, HELD} and a helper function for counter widths.
- Sub-module button_channel: synchronizer, debounce, FSM and pulse generation for one bit.
- Top holds the prescaler and a generate loop over WIDTH.

Test Plan:
Bench config: WIDTH=2, ACTIVE_LOW=1, TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=10, REPEAT_TICKS=4.
- Reset release with din=2'b11 held -> all outputs 0 for 200 clk; tick pulses every 4th clk starting at cycle 4.
- din[0] 1->0 held -> level[0]=1 and rise[0] 1-clk on the 3rd tick after the synchronised change; level[1] stays 0.
- din[0] bounces 0,1,0 on consecutive ticks then steady -> no rise until 3 consecutive pressed samples; exactly one rise.
- Hold din[0]=0 -> long_press[0] 10 ticks after rise, then rpt[0] every 4 ticks; release -> fall[0] after 3 ticks, no further rpt.
- Assert rst_n=0 mid-HELD -> level/pulses drop to 0 asynchronously; din still 0 after release -> rise again after 3 ticks.
- EXT_TICK=1, REPEAT_TICKS=0, tick_en pulsed every 7 clk -> debounce timing follows tick_en; no rpt pulses ever.
